seq_divider_8b: RTL

//  Sequential restoring divider; the inverse datapath of the 8x8 array

---
 rtl/seq_divider_8b.sv | 109 ++++++++++
 1 files changed

// File: rtl/seq_divider_8b.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one quotient
// bit per cycle, with valid/ready handshakes on the input and output sides.
module seq_divider_8b #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] quotient,
    output logic [W-1:0]   remainder,
    output logic           dbz
);
    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and data is held while valid waits.
    localparam int CW = $clog2(2 * W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_d;
    logic [W-1:0]   prem, prem_d;
    logic [2*W-1:0] sreg, sreg_d;
    logic [W-1:0]   dsor, dsor_d;
    logic [CW-1:0]  count, count_d;
    logic           dbz_d;
    logic [W:0]     t;
    logic           fits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            prem  <= '0;
            sreg  <= '0;
            dsor  <= '0;
            count <= '0;
            dbz   <= 1'b0;
        end else begin
            state <= state_d;
            prem  <= prem_d;
            sreg  <= sreg_d;
            dsor  <= dsor_d;
            count <= count_d;
            dbz   <= dbz_d;
        end
    end

    // The partial remainder is always below the divisor, so W bits hold it;
    // only the trial value t needs the extra bit for the compare.
    always_comb begin
        t         = {prem, sreg[2*W-1]};
        fits      = (t >= {1'b0, dsor});
        state_d   = state;
        prem_d    = prem;
        sreg_d    = sreg;
        dsor_d    = dsor;
        count_d   = count;
        dbz_d     = dbz;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    dsor_d = divisor;
                    if (divisor == '0) begin
                        state_d = DONE;
                        sreg_d  = '1;
                        prem_d  = dividend[W-1:0];
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                        prem_d  = '0;
                        sreg_d  = dividend;
                        count_d = CW'(2 * W - 1);
                        dbz_d   = 1'b0;
                    end
                end
            end
            CALC: begin
                prem_d = fits ? (t[W-1:0] - dsor) : t[W-1:0];
                sreg_d = {sreg[2*W-2:0], fits};
                if (count == '0) begin
                    state_d = DONE;
                end else begin
                    count_d = count - CW'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign quotient  = sreg;
    assign remainder = prem;

endmodule
